// File: rtl/microwave_controller.sv
// Microwave sequencing FSM: M:SS BCD entry, countdown, pause/resume and done beep.
// Optional door interlock enabled by defining DOOR_INTERLOCK_EN.
module microwave_controller #(
  parameter int unsigned DONE_TICKS = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  output logic       enablen,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state
);

  localparam int unsigned CW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_state_nx;
  logic [3:0]      r_min, r_tens, r_ones;
  logic [3:0]      w_min_nx, w_tens_nx, w_ones_nx;
  logic [3:0]      w_dmin, w_dtens, w_dones;
  logic [CW-1:0]   r_done_cnt, w_done_cnt_nx;
  logic            r_mag, r_done, r_enablen;
  logic            r_loadn_q, r_loadn_qq, r_tick_q, r_tick_qq;
  logic            w_load_ev, w_tick_ev;
  logic            w_time_zero, w_dec_zero, w_door_open;

  // Strobes are sampled once, then compared against their own delayed copy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_loadn_q  <= 1'b1;
      r_loadn_qq <= 1'b1;
      r_tick_q   <= 1'b0;
      r_tick_qq  <= 1'b0;
    end else begin
      r_loadn_q  <= loadn;
      r_loadn_qq <= r_loadn_q;
      r_tick_q   <= pgt_1Hz;
      r_tick_qq  <= r_tick_q;
    end
  end

  assign w_load_ev = r_loadn_qq & ~r_loadn_q;
  assign w_tick_ev = r_tick_q & ~r_tick_qq;

`ifdef DOOR_INTERLOCK_EN
  assign w_door_open = ~door_closed;
`else
  logic w_door_unused;
  assign w_door_unused = door_closed;
  assign w_door_open   = 1'b0;
`endif

  assign w_time_zero = ({r_min, r_tens, r_ones} == 12'd0);

  // Borrow from minutes always reloads 59, even if sec_tens was entered above 5.
  always_comb begin
    w_dmin  = r_min;
    w_dtens = r_tens;
    w_dones = r_ones;
    if (r_ones != 4'd0) begin
      w_dones = r_ones - 4'd1;
    end else if (r_tens != 4'd0) begin
      w_dtens = r_tens - 4'd1;
      w_dones = 4'd9;
    end else if (r_min != 4'd0) begin
      w_dmin  = r_min - 4'd1;
      w_dtens = 4'd5;
      w_dones = 4'd9;
    end
  end

  assign w_dec_zero = ({w_dmin, w_dtens, w_dones} == 12'd0);

  always_comb begin
    w_state_nx    = r_state;
    w_min_nx      = r_min;
    w_tens_nx     = r_tens;
    w_ones_nx     = r_ones;
    w_done_cnt_nx = r_done_cnt;
    case (r_state)
      S_IDLE, S_ENTRY: begin
        if (!clearn) begin
          w_state_nx = S_IDLE;
          w_min_nx   = '0;
          w_tens_nx  = '0;
          w_ones_nx  = '0;
        end else if (!startn && !w_time_zero && !w_door_open) begin
          w_state_nx = S_COOK;
        end else if (w_load_ev && (D <= 4'd9)) begin
          w_min_nx   = r_tens;
          w_tens_nx  = r_ones;
          w_ones_nx  = D;
          w_state_nx = S_ENTRY;
        end
      end
      S_COOK: begin
        if (!clearn) begin
          w_state_nx = S_IDLE;
          w_min_nx   = '0;
          w_tens_nx  = '0;
          w_ones_nx  = '0;
        end else if (w_door_open || !stopn) begin
          w_state_nx = S_PAUSE;
        end else if (w_tick_ev) begin
          w_min_nx  = w_dmin;
          w_tens_nx = w_dtens;
          w_ones_nx = w_dones;
          if (w_dec_zero) begin
            w_state_nx    = S_DONE;
            w_done_cnt_nx = '0;
          end
        end
      end
      S_PAUSE: begin
        if (!clearn) begin
          w_state_nx = S_IDLE;
          w_min_nx   = '0;
          w_tens_nx  = '0;
          w_ones_nx  = '0;
        end else if (!startn && !w_door_open) begin
          w_state_nx = S_COOK;
        end
      end
      S_DONE: begin
        if (!clearn || !stopn) begin
          w_state_nx = S_IDLE;
        end else if (w_tick_ev) begin
          if (r_done_cnt == CW'(DONE_TICKS - 1)) begin
            w_state_nx = S_IDLE;
          end else begin
            w_done_cnt_nx = r_done_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_min_nx   = '0;
        w_tens_nx  = '0;
        w_ones_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_min      <= '0;
      r_tens     <= '0;
      r_ones     <= '0;
      r_done_cnt <= '0;
      r_mag      <= 1'b0;
      r_done     <= 1'b0;
      r_enablen  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_min      <= w_min_nx;
      r_tens     <= w_tens_nx;
      r_ones     <= w_ones_nx;
      r_done_cnt <= w_done_cnt_nx;
      r_mag      <= (w_state_nx == S_COOK);
      r_done     <= (w_state_nx == S_DONE);
      r_enablen  <= (w_state_nx == S_COOK) || (w_state_nx == S_PAUSE) ||
                    (w_state_nx == S_DONE);
    end
  end

  assign state    = r_state;
  assign min_ones = r_min;
  assign sec_tens = r_tens;
  assign sec_ones = r_ones;
  assign mag_on   = r_mag;
  assign done     = r_done;
  assign enablen  = r_enablen;

endmodule

// File: tb/tb_microwave_controller.sv
// Directed self-checking bench for microwave_controller.
// Door-interlock checks switch with DOOR_INTERLOCK_EN.
module tb_microwave_controller;

  logic       clk = 1'b0;
  logic       rstn, loadn, pgt_1Hz, startn, stopn, clearn, door_closed;
  logic [3:0] D;
  logic       enablen, mag_on, done;
  logic [3:0] min_ones, sec_tens, sec_ones;
  logic [2:0] state;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  microwave_controller #(.DONE_TICKS(3)) dut (
    .clk(clk), .rstn(rstn), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .startn(startn), .stopn(stopn), .clearn(clearn), .door_closed(door_closed),
    .enablen(enablen), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .mag_on(mag_on), .done(done), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input int m, input int t, input int o);
    check({tag, ".min"},  32'(min_ones), 32'(m));
    check({tag, ".tens"}, 32'(sec_tens), 32'(t));
    check({tag, ".ones"}, 32'(sec_ones), 32'(o));
  endtask

  task automatic key(input logic [3:0] d);
    @(negedge clk); D = d; loadn = 1'b0;
    @(negedge clk); loadn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk); pgt_1Hz = 1'b1;
    @(negedge clk); pgt_1Hz = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_start();
    @(negedge clk); startn = 1'b0;
    @(negedge clk); startn = 1'b1;
    @(negedge clk);
  endtask

  task automatic press_stop();
    @(negedge clk); stopn = 1'b0;
    @(negedge clk); stopn = 1'b1;
    @(negedge clk);
  endtask

  task automatic press_clear();
    @(negedge clk); clearn = 1'b0;
    @(negedge clk); clearn = 1'b1;
    @(negedge clk);
  endtask

  // Stop is held low exactly in the cycle the tick event is seen.
  task automatic tick_with_stop();
    @(negedge clk); pgt_1Hz = 1'b1;
    @(negedge clk); pgt_1Hz = 1'b0; stopn = 1'b0;
    @(negedge clk); stopn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; loadn = 1'b1; pgt_1Hz = 1'b0; startn = 1'b1; stopn = 1'b1;
    clearn = 1'b1; door_closed = 1'b1; D = 4'd0;
    repeat (3) @(negedge clk);
    check("rst.state", 32'(state), 0);
    check_time("rst", 0, 0, 0);
    check("rst.mag", 32'(mag_on), 0);
    check("rst.done", 32'(done), 0);
    check("rst.enablen", 32'(enablen), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    key(4'd1); key(4'd3); key(4'd0);
    check_time("t1.entry", 1, 3, 0);
    check("t1.state_entry", 32'(state), 1);
    check("t1.en_entry", 32'(enablen), 0);
    press_start();
    check("t1.state_cook", 32'(state), 2);
    check("t1.mag_cook", 32'(mag_on), 1);
    check("t1.en_cook", 32'(enablen), 1);
    press_clear();
    check("t1.state_clr", 32'(state), 0);
    check_time("t1.clr", 0, 0, 0);
    check("t1.mag_clr", 32'(mag_on), 0);

    key(4'd1); key(4'd0); key(4'd0);
    check_time("t2.load", 1, 0, 0);
    press_start();
    tick();
    check_time("t2.t1", 0, 5, 9);
    ticks(58);
    check_time("t2.t59", 0, 0, 1);
    check("t2.state_cook", 32'(state), 2);
    tick();
    check_time("t2.t60", 0, 0, 0);
    check("t2.state_done", 32'(state), 4);
    check("t2.done", 32'(done), 1);
    check("t2.mag_done", 32'(mag_on), 0);
    check("t2.en_done", 32'(enablen), 1);
    ticks(2);
    check("t2.state_done2", 32'(state), 4);
    check("t2.done2", 32'(done), 1);
    tick();
    check("t2.state_idle", 32'(state), 0);
    check("t2.done_idle", 32'(done), 0);
    check("t2.en_idle", 32'(enablen), 0);

    key(4'd4); key(4'd5);
    check_time("t3.load", 0, 4, 5);
    press_start();
    tick_with_stop();
    check("t3.state_pause", 32'(state), 3);
    check_time("t3.pause", 0, 4, 5);
    check("t3.mag_pause", 32'(mag_on), 0);
    ticks(5);
    check("t3.state_pause5", 32'(state), 3);
    check_time("t3.pause5", 0, 4, 5);
    press_start();
    check("t3.state_resume", 32'(state), 2);
    check("t3.mag_resume", 32'(mag_on), 1);
    tick();
    check_time("t3.resume_tick", 0, 4, 4);
    press_clear();

    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    check_time("t4.shift", 2, 3, 4);
    key(4'd12);
    check_time("t4.bad_digit", 2, 3, 4);
    check("t4.state_entry", 32'(state), 1);
    press_clear();
    press_start();
    check("t4.start_zero", 32'(state), 0);
    check("t4.mag_zero", 32'(mag_on), 0);
    key(4'd9); key(4'd0);
    press_start();
    tick();
    check_time("t4.ninety", 0, 8, 9);
    press_clear();
    key(4'd1);
    press_start();
    tick();
    check("t4.state_done", 32'(state), 4);
    press_stop();
    check("t4.stop_done", 32'(state), 0);

    key(4'd5);
    press_start();
    @(negedge clk); door_closed = 1'b0;
    repeat (2) @(negedge clk);
`ifdef DOOR_INTERLOCK_EN
    check("t5.door_pause", 32'(state), 3);
    check("t5.door_mag", 32'(mag_on), 0);
    press_start();
    check("t5.door_start", 32'(state), 3);
    door_closed = 1'b1;
    press_start();
    check("t5.door_resume", 32'(state), 2);
`else
    check("t5.door_ignored", 32'(state), 2);
    check("t5.door_mag", 32'(mag_on), 1);
    door_closed = 1'b1;
`endif
    press_clear();

    key(4'd2); key(4'd0);
    press_start();
    check("t6.state_cook", 32'(state), 2);
    @(negedge clk); rstn = 1'b0;
    #1;
    check("t6.state", 32'(state), 0);
    check_time("t6", 0, 0, 0);
    check("t6.mag", 32'(mag_on), 0);
    check("t6.done", 32'(done), 0);
    check("t6.enablen", 32'(enablen), 0);
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
